// File: rtl/fma_stream_driver.sv
// fma_stream_driver: forks operand triples onto the FMA's three channels,
// absorbs results into a credit-protected FIFO and replays them with tlast.
module fma_stream_driver #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [3*SIZE-1:0]        s_axis_op_tdata,
    input  logic                     s_axis_op_tvalid,
    output logic                     s_axis_op_tready,
    input  logic                     s_axis_op_tlast,
    output logic [SIZE-1:0]          m_axis_a_tdata,
    output logic                     m_axis_a_tvalid,
    input  logic                     m_axis_a_tready,
    output logic [SIZE-1:0]          m_axis_b_tdata,
    output logic                     m_axis_b_tvalid,
    input  logic                     m_axis_b_tready,
    output logic [SIZE-1:0]          m_axis_c_tdata,
    output logic                     m_axis_c_tvalid,
    input  logic                     m_axis_c_tready,
    input  logic [SIZE-1:0]          s_axis_result_tdata,
    input  logic                     s_axis_result_tvalid,
    output logic                     s_axis_result_tready,
    output logic [SIZE-1:0]          m_axis_out_tdata,
    output logic                     m_axis_out_tvalid,
    input  logic                     m_axis_out_tready,
    output logic                     m_axis_out_tlast,
    output logic [$clog2(DEPTH):0]   credits_used,
    output logic                     err_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    logic [SIZE-1:0]  a_q, b_q, c_q;
    logic             pa, pb, pc;
    logic             fork_free, credit_ok, op_acc;
    logic [AW:0]      res_wp, res_rp;
    logic [AW-1:0]    last_wp;
    logic [SIZE-1:0]  res_mem [DEPTH];
    logic [DEPTH-1:0] last_mem;
    logic             res_empty, res_full, res_push, out_pop;
    logic [AW:0]      credits_q;
    logic             err_q;

    assign fork_free = (!pa || m_axis_a_tready)
                    && (!pb || m_axis_b_tready)
                    && (!pc || m_axis_c_tready);
    assign credit_ok = credits_q < DEPTH_W;
    assign s_axis_op_tready = aresetn && fork_free && credit_ok;
    assign op_acc = s_axis_op_tvalid && s_axis_op_tready;

    assign res_empty = res_wp == res_rp;
    assign res_full  = (res_wp[AW] != res_rp[AW])
                    && (res_wp[AW-1:0] == res_rp[AW-1:0]);
    assign out_pop   = m_axis_out_tvalid && m_axis_out_tready;
    // A pop in the same cycle frees the slot the push lands in.
    assign res_push  = s_axis_result_tvalid && s_axis_result_tready
                    && (!res_full || out_pop);

    assign m_axis_a_tdata  = a_q;
    assign m_axis_b_tdata  = b_q;
    assign m_axis_c_tdata  = c_q;
    assign m_axis_a_tvalid = pa;
    assign m_axis_b_tvalid = pb;
    assign m_axis_c_tvalid = pc;

    assign s_axis_result_tready = aresetn;

    assign m_axis_out_tvalid = !res_empty;
    assign m_axis_out_tdata  = res_empty ? '0 : res_mem[res_rp[AW-1:0]];
    assign m_axis_out_tlast  = !res_empty && last_mem[res_rp[AW-1:0]];

    assign credits_used = credits_q;
    assign err_overflow = err_q;

    // Fork holding register and per-channel pending bits.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            pa  <= 1'b0;
            pb  <= 1'b0;
            pc  <= 1'b0;
        end else begin
            if (op_acc) begin
                a_q <= s_axis_op_tdata[SIZE-1:0];
                b_q <= s_axis_op_tdata[2*SIZE-1:SIZE];
                c_q <= s_axis_op_tdata[3*SIZE-1:2*SIZE];
            end
            pa <= op_acc || (pa && !m_axis_a_tready);
            pb <= op_acc || (pb && !m_axis_b_tready);
            pc <= op_acc || (pc && !m_axis_c_tready);
        end
    end

    // FIFO storage; contents need no reset, pointers gate visibility.
    always_ff @(posedge aclk) begin
        if (res_push)
            res_mem[res_wp[AW-1:0]] <= s_axis_result_tdata;
        if (op_acc)
            last_mem[last_wp] <= s_axis_op_tlast;
    end

    // FIFO pointers; both FIFOs pop together so they share the read side.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            res_wp  <= '0;
            res_rp  <= '0;
            last_wp <= '0;
        end else begin
            if (res_push)
                res_wp <= res_wp + ONE_W;
            if (out_pop)
                res_rp <= res_rp + ONE_W;
            if (op_acc)
                last_wp <= last_wp + ONE_A;
        end
    end

    // Outstanding-op credits and sticky overflow flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            unique case (1'b1)
                (op_acc && !out_pop): credits_q <= credits_q + ONE_W;
                (out_pop && !op_acc): credits_q <= credits_q - ONE_W;
                default:              credits_q <= credits_q;
            endcase
            if (s_axis_result_tvalid && res_full && !out_pop)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fma_stream_driver.sv
// tb_fma_stream_driver: directed checks of fork, credits, result FIFO
// and reset behaviour against a 17-cycle in-order FMA model.
module tb_fma_stream_driver;

    localparam int SZ  = 32;
    localparam int D   = 32;
    localparam int LAT = 17;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [3*SZ-1:0] s_axis_op_tdata = '0;
    logic          s_axis_op_tvalid = 1'b0;
    logic          s_axis_op_tready;
    logic          s_axis_op_tlast = 1'b0;
    logic [SZ-1:0] m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata;
    logic          m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid;
    logic          m_axis_a_tready = 1'b1;
    logic          m_axis_b_tready = 1'b1;
    logic          m_axis_c_tready = 1'b1;
    logic [SZ-1:0] s_axis_result_tdata;
    logic          s_axis_result_tvalid;
    logic          s_axis_result_tready;
    logic [SZ-1:0] m_axis_out_tdata;
    logic          m_axis_out_tvalid;
    logic          m_axis_out_tready = 1'b1;
    logic          m_axis_out_tlast;
    logic [$clog2(D):0] credits_used;
    logic          err_overflow;

    int passes = 0;
    int total  = 0;

    always #5 aclk = ~aclk;

    fma_stream_driver #(.SIZE(SZ), .DEPTH(D)) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .s_axis_op_tdata      (s_axis_op_tdata),
        .s_axis_op_tvalid     (s_axis_op_tvalid),
        .s_axis_op_tready     (s_axis_op_tready),
        .s_axis_op_tlast      (s_axis_op_tlast),
        .m_axis_a_tdata       (m_axis_a_tdata),
        .m_axis_a_tvalid      (m_axis_a_tvalid),
        .m_axis_a_tready      (m_axis_a_tready),
        .m_axis_b_tdata       (m_axis_b_tdata),
        .m_axis_b_tvalid      (m_axis_b_tvalid),
        .m_axis_b_tready      (m_axis_b_tready),
        .m_axis_c_tdata       (m_axis_c_tdata),
        .m_axis_c_tvalid      (m_axis_c_tvalid),
        .m_axis_c_tready      (m_axis_c_tready),
        .s_axis_result_tdata  (s_axis_result_tdata),
        .s_axis_result_tvalid (s_axis_result_tvalid),
        .s_axis_result_tready (s_axis_result_tready),
        .m_axis_out_tdata     (m_axis_out_tdata),
        .m_axis_out_tvalid    (m_axis_out_tvalid),
        .m_axis_out_tready    (m_axis_out_tready),
        .m_axis_out_tlast     (m_axis_out_tlast),
        .credits_used         (credits_used),
        .err_overflow         (err_overflow)
    );

    // Small non-negative integers encoded exactly as IEEE single.
    function automatic logic [31:0] int2f(input int unsigned v);
        int msb;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) msb = i;
        m = v << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic int unsigned f2int(input logic [31:0] f);
        int e;
        if (f == 32'h0) return 0;
        e = int'(f[30:23]) - 127;
        return {8'b0, 1'b1, f[22:0]} >> (23 - e);
    endfunction

    // FMA model: joins the three channels, computes a*b+c, LAT-cycle pipe.
    int unsigned qa[$], qb[$], qc[$];
    logic [LAT-1:0] dv = '0;
    logic [31:0]    dd [LAT];
    logic           mf;
    logic [31:0]    mr;
    logic           force_v = 1'b0;
    logic [31:0]    force_d = '0;

    assign s_axis_result_tvalid = force_v | dv[LAT-1];
    assign s_axis_result_tdata  = force_v ? force_d : dd[LAT-1];

    always @(posedge aclk) begin
        if (!aresetn) begin
            qa.delete();
            qb.delete();
            qc.delete();
            dv <= '0;
        end else begin
            if (m_axis_a_tvalid && m_axis_a_tready) qa.push_back(m_axis_a_tdata);
            if (m_axis_b_tvalid && m_axis_b_tready) qb.push_back(m_axis_b_tdata);
            if (m_axis_c_tvalid && m_axis_c_tready) qc.push_back(m_axis_c_tdata);
            mf = 1'b0;
            mr = 32'h0;
            if (qa.size() > 0 && qb.size() > 0 && qc.size() > 0) begin
                mf = 1'b1;
                mr = int2f(f2int(qa.pop_front()) * f2int(qb.pop_front())
                           + f2int(qc.pop_front()));
            end
            dv <= {dv[LAT-2:0], mf};
            dd[0] <= mr;
            for (int i = 1; i < LAT; i++) dd[i] <= dd[i-1];
        end
    end

    // Output monitor.
    logic [31:0] outq[$];
    logic        lastq[$];
    always @(posedge aclk) begin
        if (aresetn && m_axis_out_tvalid && m_axis_out_tready) begin
            outq.push_back(m_axis_out_tdata);
            lastq.push_back(m_axis_out_tlast);
        end
    end

    logic [31:0] opa[100], opb[100], opc[100], expv[100];
    logic        opl[100];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        outq.delete();
        lastq.delete();
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (outq.size() < n && c < budget) begin
            @(negedge aclk);
            c++;
        end
        chk(tag, 32'(outq.size() >= n), 32'd1);
    endtask

    task automatic gen_ops(input bit rnd);
        int unsigned ia, ib, ic;
        for (int i = 0; i < 100; i++) begin
            if (rnd) begin
                ia = $urandom_range(0, 15);
                ib = $urandom_range(0, 15);
                ic = $urandom_range(0, 15);
            end else begin
                ia = i % 7 + 1;
                ib = i % 5;
                ic = i % 3;
            end
            opa[i]  = int2f(ia);
            opb[i]  = int2f(ib);
            opc[i]  = int2f(ic);
            expv[i] = int2f(ia * ib + ic);
            opl[i]  = rnd ? (i % 8 == 7) : (i % 4 == 3);
        end
    endtask

    // Presents ops lo..hi-1; returns next unaccepted index and stall cycles.
    task automatic issue(input int lo, input int hi, input int budget,
                         output int nxt, output int stalls);
        nxt = lo;
        stalls = 0;
        for (int cyc = 0; cyc < budget && nxt < hi; cyc++) begin
            @(negedge aclk);
            s_axis_op_tvalid = 1'b1;
            s_axis_op_tdata  = {opc[nxt], opb[nxt], opa[nxt]};
            s_axis_op_tlast  = opl[nxt];
            #1;
            if (s_axis_op_tready) nxt++;
            else stalls++;
        end
        @(negedge aclk);
        s_axis_op_tvalid = 1'b0;
    endtask

    int nxt, stalls;

    initial begin
        // Reset state.
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("op_tready_in_reset", 32'(s_axis_op_tready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rst_op_tready", 32'(s_axis_op_tready), 32'd1);
        chk("rst_res_tready", 32'(s_axis_result_tready), 32'd1);
        chk("rst_abc_tvalid", 32'({m_axis_a_tvalid, m_axis_b_tvalid,
                                   m_axis_c_tvalid}), 32'd0);
        chk("rst_out_tvalid", 32'(m_axis_out_tvalid), 32'd0);
        chk("rst_credits", 32'(credits_used), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);

        // Single op: 1*2+3 = 5.
        @(negedge aclk);
        s_axis_op_tdata  = {32'h40400000, 32'h40000000, 32'h3F800000};
        s_axis_op_tlast  = 1'b1;
        s_axis_op_tvalid = 1'b1;
        #1;
        chk("single_accept", 32'(s_axis_op_tready), 32'd1);
        @(negedge aclk);
        s_axis_op_tvalid = 1'b0;
        #1;
        chk("single_credits_1", 32'(credits_used), 32'd1);
        chk("single_a_valid", 32'(m_axis_a_tvalid), 32'd1);
        chk("single_a_data", m_axis_a_tdata, 32'h3F800000);
        chk("single_out_early", 32'(m_axis_out_tvalid), 32'd0);
        wait_out(1, 60, "single_timeout");
        if (outq.size() >= 1) begin
            chk("single_data", outq[0], 32'h40A00000);
            chk("single_tlast", 32'(lastq[0]), 32'd1);
        end
        #1;
        chk("single_credits_0", 32'(credits_used), 32'd0);

        // Skewed fork: b ready after 5 cycles, c after 2.
        outq.delete();
        lastq.delete();
        m_axis_b_tready = 1'b0;
        m_axis_c_tready = 1'b0;
        @(negedge aclk);
        s_axis_op_tdata  = {int2f(4), int2f(3), int2f(2)};
        s_axis_op_tlast  = 1'b0;
        s_axis_op_tvalid = 1'b1;
        #1;
        chk("skew_accept1", 32'(s_axis_op_tready), 32'd1);
        for (int t = 1; t <= 6; t++) begin
            @(negedge aclk);
            if (t == 1) begin
                s_axis_op_tdata = {int2f(1), int2f(1), int2f(1)};
                s_axis_op_tlast = 1'b1;
            end
            m_axis_b_tready = (t >= 6);
            m_axis_c_tready = (t >= 3);
            #1;
            chk($sformatf("skew_a_valid_t%0d", t), 32'(m_axis_a_tvalid), 32'(t == 1));
            chk($sformatf("skew_b_valid_t%0d", t), 32'(m_axis_b_tvalid), 32'd1);
            chk($sformatf("skew_c_valid_t%0d", t), 32'(m_axis_c_tvalid), 32'(t <= 3));
            chk($sformatf("skew_op_ready_t%0d", t), 32'(s_axis_op_tready), 32'(t == 6));
        end
        @(negedge aclk);
        s_axis_op_tvalid = 1'b0;
        m_axis_c_tready = 1'b1;
        #1;
        chk("skew_op2_valid", 32'({m_axis_a_tvalid, m_axis_b_tvalid,
                                   m_axis_c_tvalid}), 32'd7);
        chk("skew_op2_b_data", m_axis_b_tdata, int2f(1));
        wait_out(2, 80, "skew_timeout");
        if (outq.size() >= 2) begin
            chk("skew_res0", outq[0], int2f(10));
            chk("skew_last0", 32'(lastq[0]), 32'd0);
            chk("skew_res1", outq[1], int2f(2));
            chk("skew_last1", 32'(lastq[1]), 32'd1);
        end

        // Credit exhaustion: 40 ops, consumer stalled.
        do_reset();
        gen_ops(1'b0);
        m_axis_out_tready = 1'b0;
        issue(0, 40, 80, nxt, stalls);
        #1;
        chk("credit_accepted", 32'(nxt), 32'(D));
        chk("credit_op_ready", 32'(s_axis_op_tready), 32'd0);
        chk("credit_used", 32'(credits_used), 32'(D));
        m_axis_out_tready = 1'b1;
        issue(nxt, 40, 300, nxt, stalls);
        chk("credit_all_accepted", 32'(nxt), 32'd40);
        wait_out(40, 200, "credit_timeout");
        for (int i = 0; i < 40; i++)
            if (outq.size() > i) begin
                chk($sformatf("credit_res%0d", i), outq[i], expv[i]);
                chk($sformatf("credit_last%0d", i), 32'(lastq[i]), 32'(opl[i]));
            end
        chk("credit_err", 32'(err_overflow), 32'd0);

        // Full-rate random stream.
        do_reset();
        gen_ops(1'b1);
        issue(0, 100, 200, nxt, stalls);
        chk("rate_accepted", 32'(nxt), 32'd100);
        chk("rate_stalls", 32'(stalls), 32'd0);
        wait_out(100, 100, "rate_timeout");
        for (int i = 0; i < 100; i++)
            if (outq.size() > i) begin
                chk($sformatf("rate_res%0d", i), outq[i], expv[i]);
                chk($sformatf("rate_last%0d", i), 32'(lastq[i]), 32'(i % 8 == 7));
            end

        // Simultaneous push/pop at a full result FIFO.
        do_reset();
        gen_ops(1'b0);
        m_axis_out_tready = 1'b0;
        issue(0, D, 100, nxt, stalls);
        repeat (LAT + 10) @(negedge aclk);
        #1;
        chk("full_credits", 32'(credits_used), 32'(D));
        chk("full_op_ready", 32'(s_axis_op_tready), 32'd0);
        @(negedge aclk);
        force_v = 1'b1;
        force_d = 32'hDEAD0001;
        m_axis_out_tready = 1'b1;
        @(negedge aclk);
        force_v = 1'b0;
        m_axis_out_tready = 1'b0;
        #1;
        chk("full_pp_err", 32'(err_overflow), 32'd0);
        chk("full_pp_pops", 32'(outq.size()), 32'd1);
        if (outq.size() >= 1)
            chk("full_pp_head", outq[0], expv[0]);
        chk("full_pp_credits", 32'(credits_used), 32'(D - 1));
        @(negedge aclk);
        force_v = 1'b1;
        force_d = 32'hDEAD0002;
        @(negedge aclk);
        force_v = 1'b0;
        #1;
        chk("full_ovf_err", 32'(err_overflow), 32'd1);
        m_axis_out_tready = 1'b1;
        repeat (50) @(negedge aclk);
        #1;
        chk("full_drain_count", 32'(outq.size()), 32'(D + 1));
        for (int i = 1; i < D; i++)
            if (outq.size() > i)
                chk($sformatf("full_res%0d", i), outq[i], expv[i]);
        if (outq.size() > D)
            chk("full_pushed", outq[D], 32'hDEAD0001);
        chk("full_err_sticky", 32'(err_overflow), 32'd1);
        do_reset();
        #1;
        chk("full_err_cleared", 32'(err_overflow), 32'd0);

        // Reset with an op pending on all three fork channels.
        m_axis_a_tready = 1'b0;
        m_axis_b_tready = 1'b0;
        m_axis_c_tready = 1'b0;
        @(negedge aclk);
        s_axis_op_tdata  = {int2f(1), int2f(2), int2f(3)};
        s_axis_op_tvalid = 1'b1;
        #1;
        chk("mid_accept", 32'(s_axis_op_tready), 32'd1);
        @(negedge aclk);
        s_axis_op_tvalid = 1'b0;
        #1;
        chk("mid_pending", 32'({m_axis_a_tvalid, m_axis_b_tvalid,
                                m_axis_c_tvalid}), 32'd7);
        chk("mid_credits_1", 32'(credits_used), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("mid_abc_tvalid", 32'({m_axis_a_tvalid, m_axis_b_tvalid,
                                   m_axis_c_tvalid}), 32'd0);
        chk("mid_out_tvalid", 32'(m_axis_out_tvalid), 32'd0);
        chk("mid_credits_0", 32'(credits_used), 32'd0);
        chk("mid_op_ready", 32'(s_axis_op_tready), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
